// File: rtl/sm83_bus_pkg.sv
// Shared types and constants for the SM83 bus responder: FSM states, address
// regions, region decode helper.
package sm83_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_EXT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_HRAM = 2'd0,
    RG_IE   = 2'd1,
    RG_EXT  = 2'd2
  } region_t;

  localparam logic [15:0] HRAM_BASE = 16'hff80;
  localparam logic [15:0] IE_ADR    = 16'hffff;
  localparam logic [15:0] ECHO_BASE = 16'he000;
  localparam logic [15:0] ECHO_END  = 16'hfdff;
  localparam logic [15:0] ECHO_OFS  = 16'h2000;
  localparam logic [7:0]  TMO_MAX   = 8'hff;

  function automatic region_t decode(input logic [15:0] a);
    if (a == IE_ADR)    return RG_IE;
    if (a >= HRAM_BASE) return RG_HRAM;
    return RG_EXT;
  endfunction

endpackage

// File: rtl/sm83_hram.sv
// 127x8 high RAM: synchronous write, combinational read. Contents are never reset.
module sm83_hram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] adr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:126];

  always_ff @(posedge clk)
    if (we) mem[adr] <= wdata;

  assign rdata = mem[adr];

endmodule

// File: rtl/sm83_bus_resp.sv
// SM83 CPU bus responder: internal HRAM/IE, everything else forwarded to an
// external port with a wait-count timeout. Define SM83_ECHO_RAM_EN to fold E000-FDFF down by 2000.
module sm83_bus_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] apin,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        doe,
  output logic        rdy,
  output logic        busy,
  output logic        ext_req,
  output logic [15:0] ext_adr,
  output logic        ext_we,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        tmo
);
  import sm83_bus_pkg::*;

  state_t      state;
  region_t     region;
  logic [15:0] adr_q;
  logic [7:0]  din_q;
  logic        rd_q;
  logic [7:0]  ie;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [15:0] fwd_adr;
  logic        hram_we;
  logic [7:0]  hram_rdata;

  assign region  = decode(adr_q);
  assign cnt_nxt = cnt + 8'd1;
  assign hram_we = (state == ST_DEC) && (region == RG_HRAM) && !rd_q;

  always_comb begin
    fwd_adr = adr_q;
`ifdef SM83_ECHO_RAM_EN
    if (adr_q >= ECHO_BASE && adr_q <= ECHO_END) fwd_adr = adr_q - ECHO_OFS;
`endif
  end

  sm83_hram u_hram (
    .clk   (clk),
    .we    (hram_we),
    .adr   (adr_q[6:0]),
    .wdata (din_q),
    .rdata (hram_rdata)
  );

  assign rdy  = (state == ST_DONE);
  assign doe  = (state == ST_DONE) && rd_q;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      adr_q     <= '0;
      din_q     <= '0;
      rd_q      <= 1'b0;
      dout      <= '0;
      ie        <= '0;
      cnt       <= '0;
      tmo       <= 1'b0;
      ext_req   <= 1'b0;
      ext_adr   <= '0;
      ext_we    <= 1'b0;
      ext_wdata <= '0;
    end else begin
      tmo <= 1'b0;
      case (state)
        ST_IDLE:
          if (rd ^ wr) begin
            adr_q <= apin;
            din_q <= din;
            rd_q  <= rd;
            state <= ST_DEC;
          end
        ST_DEC:
          if (region == RG_EXT) begin
            state     <= ST_EXT;
            ext_req   <= 1'b1;
            ext_adr   <= fwd_adr;
            ext_we    <= !rd_q;
            ext_wdata <= din_q;
            cnt       <= '0;
          end else begin
            state <= ST_DONE;
            if (rd_q)                dout <= (region == RG_IE) ? ie : hram_rdata;
            else if (region == RG_IE) ie  <= din_q;
          end
        ST_EXT: begin
          cnt <= cnt_nxt;
          // ack takes priority over a timeout landing in the same cycle
          if (ext_ack) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            if (rd_q) dout <= ext_rdata;
            state   <= ST_DONE;
          end else if (cnt_nxt == TMO_MAX) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            tmo     <= 1'b1;
            if (rd_q) dout <= 8'hff;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
